// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and memory.
// Handshake: the master holds IMemReq=1 with a stable IMemAddr until the slave
// answers with IMemAck=1, which also qualifies IMemData in that same cycle;
// at most one request is outstanding at a time.
interface fetch_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;

    modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemData);
    modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemData);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-entry fetch buffer, FETCH/HAVE request FSM
// and the IF/ID pipeline register. FetchState exposes the FSM (0=FETCH, 1=HAVE).
module fetch_stage (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 PCWrite,
    input  logic                 IF_ID_Write,
    input  logic                 IF_ID_flush,
    input  logic                 jumpReg,
    input  logic                 jump,
    input  logic                 branch,
    input  logic [31:0]          RegTarget,
    input  logic [31:0]          JumpTarget,
    input  logic [31:0]          BranchTarget,
    fetch_stage_if.master        imem,
    output logic [31:0]          IF_ID_Instr,
    output logic [31:0]          IF_ID_PC4,
    output logic                 IF_ID_Valid,
    output logic [31:0]          PC,
    output logic                 FetchState
);

    typedef enum logic {FETCH = 1'b0, HAVE = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] buf_pc4, buf_pc4_nxt;
    logic        squash, squash_nxt;
    logic        redirect;
    logic        advance;
    logic [31:0] target;

    // A redirect only counts when the hazard unit lets the PC move.
    assign redirect = PCWrite & (jumpReg | jump | branch);
    assign target   = jumpReg ? RegTarget : (jump ? JumpTarget : BranchTarget);
    assign advance  = (state == HAVE) & PCWrite & IF_ID_Write & ~redirect;

    // The request is forced low while reset is asserted, even combinationally.
    assign imem.IMemReq  = Rst & (state == FETCH);
    assign imem.IMemAddr = req_addr;
    assign FetchState    = state;

    // Next-state logic for the fetch FSM, PC, request address and buffer.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = PC;
        req_addr_nxt  = req_addr;
        buf_instr_nxt = buf_instr;
        buf_pc4_nxt   = buf_pc4;
        squash_nxt    = squash;
        if (state == FETCH) begin
            if (imem.IMemAck) begin
                if (squash || redirect) begin
                    // Returned word belongs to an abandoned path: drop it and
                    // re-request from wherever the PC now points.
                    squash_nxt   = 1'b0;
                    pc_nxt       = redirect ? target : PC;
                    req_addr_nxt = redirect ? target : PC;
                end else begin
                    buf_instr_nxt = imem.IMemData;
                    buf_pc4_nxt   = req_addr + 32'd4;
                    state_nxt     = HAVE;
                end
            end else if (redirect) begin
                // Request in flight cannot be withdrawn; remember to drop it.
                pc_nxt     = target;
                squash_nxt = 1'b1;
            end
        end else begin
            if (redirect) begin
                pc_nxt       = target;
                req_addr_nxt = target;
                state_nxt    = FETCH;
            end else if (advance) begin
                pc_nxt       = PC + 32'd4;
                req_addr_nxt = PC + 32'd4;
                state_nxt    = FETCH;
            end
        end
    end

    // State registers for the fetch FSM, PC and fetch buffer.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= FETCH;
            PC        <= 32'd0;
            req_addr  <= 32'd0;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
            squash    <= 1'b0;
        end else begin
            state     <= state_nxt;
            PC        <= pc_nxt;
            req_addr  <= req_addr_nxt;
            buf_instr <= buf_instr_nxt;
            buf_pc4   <= buf_pc4_nxt;
            squash    <= squash_nxt;
        end
    end

    // IF/ID register: flush beats load, a write without a buffered word is a bubble.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            IF_ID_Instr <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_Valid <= 1'b0;
        end else if (IF_ID_flush) begin
            IF_ID_Instr <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_Valid <= 1'b0;
        end else if (IF_ID_Write && advance) begin
            IF_ID_Instr <= buf_instr;
            IF_ID_PC4   <= buf_pc4;
            IF_ID_Valid <= 1'b1;
        end else if (IF_ID_Write) begin
            IF_ID_Instr <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-by-cycle vector bench for fetch_stage: each record gives the inputs for
// one clock and the outputs expected just after that edge.
module tb_fetch_stage;

    localparam int EW = 131;
    localparam logic [31:0] RT = 32'h100;
    localparam logic [31:0] JT = 32'h200;
    localparam logic [31:0] BT = 32'h300;

    typedef struct {
        logic [7:0]  c;   // {rst, pcw, ifw, flush, jr, j, br, ack}
        logic [31:0] d;
        logic [31:0] rt;
        logic [31:0] jt;
        logic [31:0] bt;
        logic        er;
        logic [31:0] ea;
        logic [31:0] ep;
        logic [31:0] ei;
        logic [31:0] e4;
        logic        ev;
    } vec_t;

    // clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        pc_write, if_id_write, if_id_flush, jump_reg, jump, branch;
    logic [31:0] reg_target, jump_target, branch_target;
    logic [31:0] if_id_instr, if_id_pc4, pc;
    logic        if_id_valid, fetch_state;

    fetch_stage_if imem ();

    fetch_stage dut (
        .Clk          (clk),
        .Rst          (rst),
        .PCWrite      (pc_write),
        .IF_ID_Write  (if_id_write),
        .IF_ID_flush  (if_id_flush),
        .jumpReg      (jump_reg),
        .jump         (jump),
        .branch       (branch),
        .RegTarget    (reg_target),
        .JumpTarget   (jump_target),
        .BranchTarget (branch_target),
        .imem         (imem.master),
        .IF_ID_Instr  (if_id_instr),
        .IF_ID_PC4    (if_id_pc4),
        .IF_ID_Valid  (if_id_valid),
        .PC           (pc),
        .FetchState   (fetch_state)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic [7:0] c, input logic [31:0] d,
                                input logic [31:0] rt, input logic [31:0] jt,
                                input logic [31:0] bt, input logic er,
                                input logic [31:0] ea, input logic [31:0] ep,
                                input logic [31:0] ei, input logic [31:0] e4,
                                input logic ev);
        vec_t v;
        v.c = c; v.d = d; v.rt = rt; v.jt = jt; v.bt = bt;
        v.er = er; v.ea = ea; v.ep = ep; v.ei = ei; v.e4 = e4; v.ev = ev;
        return v;
    endfunction

    // driver: inputs at negedge, expected pushed, outputs compared 1ns after posedge
    task automatic apply(input vec_t v, input string name);
        logic [EW-1:0] exp_w, got_w;
        logic          exp_state;
        @(negedge clk);
        rst           = v.c[7];
        pc_write      = v.c[6];
        if_id_write   = v.c[5];
        if_id_flush   = v.c[4];
        jump_reg      = v.c[3];
        jump          = v.c[2];
        branch        = v.c[1];
        imem.IMemAck  = v.c[0];
        imem.IMemData = v.d;
        reg_target    = v.rt;
        jump_target   = v.jt;
        branch_target = v.bt;
        // Outside reset the FSM is in HAVE exactly when no request is raised.
        exp_state = v.c[7] & ~v.er;
        exp_q.push_back({v.er, exp_state, v.ea, v.ep, v.ei, v.e4, v.ev});
        @(posedge clk);
        #1;
        got_w = {imem.IMemReq, fetch_state, imem.IMemAddr, pc, if_id_instr, if_id_pc4, if_id_valid};
        exp_w = exp_q.pop_front();
        n_vec++;
        if (got_w !== exp_w) begin
            n_err++;
            $display("FAIL %s: got req=%0b st=%0b addr=%h pc=%h instr=%h pc4=%h valid=%0b, expected req=%0b st=%0b addr=%h pc=%h instr=%h pc4=%h valid=%0b",
                     name, got_w[130], got_w[129], got_w[128:97], got_w[96:65], got_w[64:33], got_w[32:1], got_w[0],
                     exp_w[130], exp_w[129], exp_w[128:97], exp_w[96:65], exp_w[64:33], exp_w[32:1], exp_w[0]);
        end
    endtask

    vec_t tbl[24];

    initial begin
        rst = 1'b0; pc_write = 1'b0; if_id_write = 1'b0; if_id_flush = 1'b0;
        jump_reg = 1'b0; jump = 1'b0; branch = 1'b0;
        reg_target = RT; jump_target = JT; branch_target = BT;
        imem.IMemAck = 1'b0; imem.IMemData = 32'd0;

        //            ctrl          data          rt            jt  bt  req addr          pc            instr         pc4         valid
        tbl[0]  = mk(8'b0000_0000, 32'h0,        RT,           JT, BT, 0, 32'h0,        32'h0,        32'h0,        32'h0,      0);
        tbl[1]  = mk(8'b0110_0001, 32'hFFFFFFFF, RT,           JT, BT, 0, 32'h0,        32'h0,        32'h0,        32'h0,      0);
        tbl[2]  = mk(8'b1110_0001, 32'h20080001, RT,           JT, BT, 0, 32'h0,        32'h0,        32'h0,        32'h0,      0);
        tbl[3]  = mk(8'b1110_0000, 32'h0,        RT,           JT, BT, 1, 32'h4,        32'h4,        32'h20080001, 32'h4,      1);
        tbl[4]  = mk(8'b1110_0001, 32'h11111111, RT,           JT, BT, 0, 32'h4,        32'h4,        32'h0,        32'h0,      0);
        tbl[5]  = mk(8'b1110_0000, 32'h0,        RT,           JT, BT, 1, 32'h8,        32'h8,        32'h11111111, 32'h8,      1);
        tbl[6]  = mk(8'b1111_0001, 32'h22222222, RT,           JT, BT, 0, 32'h8,        32'h8,        32'h0,        32'h0,      0);
        tbl[7]  = mk(8'b1100_0000, 32'h0,        RT,           JT, BT, 0, 32'h8,        32'h8,        32'h0,        32'h0,      0);
        tbl[8]  = mk(8'b1100_1110, 32'h0,        RT,           JT, BT, 1, 32'h100,      32'h100,      32'h0,        32'h0,      0);
        tbl[9]  = mk(8'b1110_0001, 32'h33333333, RT,           JT, BT, 0, 32'h100,      32'h100,      32'h0,        32'h0,      0);
        tbl[10] = mk(8'b1111_0000, 32'h0,        RT,           JT, BT, 1, 32'h104,      32'h104,      32'h0,        32'h0,      0);
        tbl[11] = mk(8'b1100_0010, 32'h0,        RT,           JT, BT, 1, 32'h104,      32'h300,      32'h0,        32'h0,      0);
        tbl[12] = mk(8'b1000_0001, 32'hDEADBEEF, RT,           JT, BT, 1, 32'h300,      32'h300,      32'h0,        32'h0,      0);
        tbl[13] = mk(8'b1110_0001, 32'h44444444, RT,           JT, BT, 0, 32'h300,      32'h300,      32'h0,        32'h0,      0);
        tbl[14] = mk(8'b1110_0000, 32'h0,        RT,           JT, BT, 1, 32'h304,      32'h304,      32'h44444444, 32'h304,    1);
        tbl[15] = mk(8'b1100_0111, 32'h55555555, RT,           JT, BT, 1, 32'h200,      32'h200,      32'h44444444, 32'h304,    1);
        tbl[16] = mk(8'b1000_1000, 32'h0,        RT,           JT, BT, 1, 32'h200,      32'h200,      32'h44444444, 32'h304,    1);
        tbl[17] = mk(8'b1100_1001, 32'h5A5A5A5A, 32'hFFFFFFFC, JT, BT, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h44444444, 32'h304,    1);
        tbl[18] = mk(8'b1110_0001, 32'h66666666, RT,           JT, BT, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,      0);
        tbl[19] = mk(8'b1110_0000, 32'h0,        RT,           JT, BT, 1, 32'h0,        32'h0,        32'h66666666, 32'h0,      1);
        tbl[20] = mk(8'b1100_1000, 32'h0,        32'h123,      JT, BT, 1, 32'h0,        32'h123,      32'h66666666, 32'h0,      1);
        tbl[21] = mk(8'b1000_0001, 32'h12345678, RT,           JT, BT, 1, 32'h123,      32'h123,      32'h66666666, 32'h0,      1);
        tbl[22] = mk(8'b1110_0001, 32'h77777777, RT,           JT, BT, 0, 32'h123,      32'h123,      32'h0,        32'h0,      0);
        tbl[23] = mk(8'b1110_0000, 32'h0,        RT,           JT, BT, 1, 32'h127,      32'h127,      32'h77777777, 32'h127,    1);

        for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // stall in HAVE for five cycles, then release
        apply(mk(8'b1000_0001, 32'h88888888, RT, JT, BT, 0, 32'h127, 32'h127, 32'h77777777, 32'h127, 1), "stall_fill");
        for (int i = 0; i < 5; i++)
            apply(mk(8'b1000_0000, 32'h0, RT, JT, BT, 0, 32'h127, 32'h127, 32'h77777777, 32'h127, 1), $sformatf("stall%0d", i));
        apply(mk(8'b1110_0000, 32'h0, RT, JT, BT, 1, 32'h12B, 32'h12B, 32'h88888888, 32'h12B, 1), "stall_release");

        // redirect while a request is outstanding: address held, late ack dropped
        apply(mk(8'b1100_0101, 32'h0, RT, 32'h10, BT, 1, 32'h10, 32'h10, 32'h88888888, 32'h12B, 1), "goto_10");
        apply(mk(8'b1100_0100, 32'h0, RT, 32'h40, BT, 1, 32'h10, 32'h40, 32'h88888888, 32'h12B, 1), "jump_pending");
        for (int i = 0; i < 2; i++)
            apply(mk(8'b1000_0000, 32'h0, RT, JT, BT, 1, 32'h10, 32'h40, 32'h88888888, 32'h12B, 1), $sformatf("wait_ack%0d", i));
        apply(mk(8'b1000_0001, 32'h99999999, RT, JT, BT, 1, 32'h40, 32'h40, 32'h88888888, 32'h12B, 1), "stale_ack");
        apply(mk(8'b1110_0001, 32'hAAAAAAAA, RT, JT, BT, 0, 32'h40, 32'h40, 32'h0, 32'h0, 0), "fetch_40");
        apply(mk(8'b1110_0000, 32'h0, RT, JT, BT, 1, 32'h44, 32'h44, 32'hAAAAAAAA, 32'h44, 1), "issue_40");

        // reset in the middle of a handshake
        apply(mk(8'b1100_0101, 32'h0, RT, 32'h24, BT, 1, 32'h24, 32'h24, 32'hAAAAAAAA, 32'h44, 1), "goto_24");
        apply(mk(8'b0000_0001, 32'hBBBBBBBB, RT, JT, BT, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0), "mid_reset");
        apply(mk(8'b1000_0000, 32'h0, RT, JT, BT, 1, 32'h0, 32'h0, 32'h0, 32'h0, 0), "after_reset");
        apply(mk(8'b1110_0001, 32'hCCCCCCCC, RT, JT, BT, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0), "refetch_0");
        apply(mk(8'b1110_0000, 32'h0, RT, JT, BT, 1, 32'h4, 32'h4, 32'hCCCCCCCC, 32'h4, 1), "reissue_0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst  input  1  reset, synchronous, active-low; sampled only on rising Clk.
REQ-003 PCWrite  input  1  PC update enable from hazard detection; 0 = stall PC.
REQ-004 IF_ID_Write  input  1  IF/ID register load enable from hazard detection.
REQ-005 IF_ID_flush  input  1  IF/ID register clear (insert bubble).
REQ-006 jumpReg, jump, branch  input  1 each  redirect requests from ID.
REQ-007 RegTarget, JumpTarget, BranchTarget  input  32 each  redirect targets for jumpReg / jump / branch.
REQ-008 IMemReq  output  1  instruction memory request.
REQ-009 IMemAddr  output  32  request address; stable while IMemReq=1 until IMemAck.
REQ-010 IMemAck  input  1  memory response valid; IMemData valid same cycle.
REQ-011 IMemData  input  32  fetched instruction word.
REQ-012 IF_ID_Instr  output  32  registered instruction to ID.
REQ-013 IF_ID_PC4  output  32  registered PC+4 of IF_ID_Instr.
REQ-014 IF_ID_Valid  output  1  1 = IF_ID_Instr is a real instruction, 0 = bubble.
REQ-015 PC  output  32  current program counter (debug/observe).

Function
REQ-016 Redirect = PCWrite & (jumpReg | jump | branch); target priority jumpReg > jump > branch.
REQ-017 FSM states: FETCH (IMemReq=1, awaiting ack) and HAVE (IMemReq=0, word held in internal fetch buffer).
REQ-018 FETCH, IMemAck=1, no Squash, no Redirect: buffer <= IMemData (paired with ReqAddr+4); next state HAVE.
REQ-019 FETCH, IMemAck=1, Squash=1 or Redirect same cycle: IMemData discarded; Squash <= 0; ReqAddr <= new PC (target if Redirect, else current PC); stay FETCH.
REQ-020 FETCH, IMemAck=0, Redirect: PC <= target; Squash <= 1; IMemReq and IMemAddr held unchanged (no request abandonment).
REQ-021 FETCH, no Redirect: PCWrite ignored; PC holds.
REQ-022 Advance = state HAVE & PCWrite & IF_ID_Write & no Redirect: PC <= PC+4 (mod 2^32, wrap 0xFFFFFFFC -> 0x00000000); ReqAddr <= PC+4; next FETCH.
REQ-023 HAVE, Redirect: buffer discarded; PC <= target; ReqAddr <= target; next FETCH.
REQ-024 HAVE, neither Advance nor Redirect (stall): all state held; IMemReq=0.
REQ-025 IMemAddr = ReqAddr register; new request issued the cycle after entering FETCH; one request outstanding maximum.
REQ-026 IF/ID update priority: IF_ID_flush -> Instr=0x00000000, PC4=0, Valid=0; else IF_ID_Write & Advance -> Instr=buffer, PC4=buffer PC+4, Valid=1; else IF_ID_Write -> bubble (Instr=0, PC4=0, Valid=0); else hold.
REQ-027 Flush and Advance same cycle: IF/ID clears, PC still advances (hazard unit never asserts both; defined behaviour regardless).
REQ-028 Latency: ack to IF_ID_Valid=1 minimum 2 cycles (capture into buffer, then IF/ID load); sustained throughput one instruction per 2 cycles minimum with zero-wait memory.
REQ-029 Targets used unaligned as given; no alignment check.

Reset
REQ-030 While Rst=0 at an edge: PC=0x00000000, ReqAddr=0, state FETCH, Squash=0, buffer invalid, IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0.
REQ-031 IMemReq=0 during any cycle Rst=0; IMemAck ignored while Rst=0.
REQ-032 Reset mid-handshake abandons outstanding request; first cycle after release drives IMemReq=1, IMemAddr=0.

Verification
REQ-033 Reset release, zero-wait memory returning 0x20080001 at addr 0, no hazards -> IF_ID_Instr=0x20080001, PC4=4, Valid=1 two cycles after ack; next IMemAddr=4.
REQ-034 HAVE with PCWrite=0, IF_ID_Write=0 for 5 cycles -> PC, IF_ID_* and IMemReq=0 unchanged; release -> advances PC by 4.
REQ-035 FETCH at 0x10, IMemAck=0, jump=1, PCWrite=1, JumpTarget=0x40 -> IMemAddr stays 0x10; ack 3 cycles later discarded; next IMemAddr=0x40, PC=0x40.
REQ-036 jumpReg=1, jump=1, branch=1 together, targets 0x100/0x200/0x300 -> PC=0x100.
REQ-037 IF_ID_flush=1 with IF_ID_Valid=1 -> next cycle Instr=0, PC4=0, Valid=0.
REQ-038 Rst=0 asserted while IMemReq=1 at 0x24 -> next edge all outputs per REQ-030; after release IMemAddr=0.
